switch_allocator: RTL and testbench

//  Per-router switch allocator driving the one-hot select inputs of the 5x5 crossbar.

---
 rtl/switch_allocator.sv | 104 ++++++++++
 tb/tb_switch_allocator.sv | 104 ++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// switch_allocator: 5x5 crossbar switch allocator, round-robin per output with wormhole locks.
// Define SA_LOCK_TIMEOUT_EN to break stale locks after LOCK_TIMEOUT idle cycles.
module switch_allocator #(
   parameter int LOCK_TIMEOUT = 64,
   parameter int TO_W         = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] req,
   input  logic [4:0] dest0,
   input  logic [4:0] dest1,
   input  logic [4:0] dest2,
   input  logic [4:0] dest3,
   input  logic [4:0] dest4,
   input  logic [4:0] tail,
   input  logic [4:0] out_rdy,
   output logic [4:0] sel0,
   output logic [4:0] sel1,
   output logic [4:0] sel2,
   output logic [4:0] sel3,
   output logic [4:0] sel4,
   output logic [4:0] ack,
   output logic [4:0] lock_err
);
   if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT >= (1 << TO_W)) begin : g_bad_cfg
      $error("switch_allocator: TO_W cannot hold LOCK_TIMEOUT");
   end
   function automatic logic [2:0] wrap(input logic [2:0] a, input int i);
      int s = int'(a) + i;
      return 3'(s >= 5 ? s - 5 : s);
   endfunction
   logic [4:0] dest [5];
   logic [4:0] elig [5];
   logic [4:0] sel  [5];
   logic [2:0] win  [5];
   logic [2:0] owner [5];
   logic [2:0] ptr  [5];
   logic [4:0] locked;
   logic [4:0] gnt;
   assign dest[0] = dest0;
   assign dest[1] = dest1;
   assign dest[2] = dest2;
   assign dest[3] = dest3;
   assign dest[4] = dest4;
   // Reverse search lets the last hit be the first eligible input from ptr onward.
   always_comb
      for (int o = 0; o < 5; o++) begin
         elig[o] = '0;
         sel[o]  = '0;
         win[o]  = owner[o];
         gnt[o]  = 1'b0;
         for (int k = 0; k < 5; k++) elig[o][k] = req[k] & dest[k][o] & $onehot(dest[k]);
         if (!rst && out_rdy[o]) begin
            if (locked[o]) gnt[o] = elig[o][owner[o]];
            else begin
               for (int i = 4; i >= 0; i--) if (elig[o][wrap(ptr[o], i)]) win[o] = wrap(ptr[o], i);
               gnt[o] = |elig[o];
            end
            if (gnt[o]) sel[o][win[o]] = 1'b1;
         end
      end
   assign sel0 = sel[0];
   assign sel1 = sel[1];
   assign sel2 = sel[2];
   assign sel3 = sel[3];
   assign sel4 = sel[4];
   assign ack  = sel[0] | sel[1] | sel[2] | sel[3] | sel[4];
`ifdef SA_LOCK_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
   logic [TO_W-1:0] cnt [5];
   logic [4:0] expire;
   always_comb
      for (int o = 0; o < 5; o++) expire[o] = locked[o] && !gnt[o] && cnt[o] == TO_LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         lock_err <= '0;
         for (int o = 0; o < 5; o++) cnt[o] <= '0;
      end else begin
         lock_err <= expire;
         for (int o = 0; o < 5; o++) cnt[o] <= (gnt[o] || !locked[o] || expire[o]) ? '0 : cnt[o] + 1'b1;
      end
`else
   logic [4:0] expire;
   assign expire   = '0;
   assign lock_err = '0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         locked <= '0;
         for (int o = 0; o < 5; o++) begin
            owner[o] <= '0;
            ptr[o]   <= '0;
         end
      end else
         for (int o = 0; o < 5; o++)
            if (gnt[o]) begin
               owner[o]  <= win[o];
               locked[o] <= ~tail[win[o]];
               if (!locked[o]) ptr[o] <= wrap(win[o], 1);
            end else if (expire[o]) begin
               locked[o] <= 1'b0;
               ptr[o]    <= wrap(owner[o], 1);
            end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_switch_allocator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] req = '0, tail = '0, out_rdy = '1;
   logic [4:0] d [5];
   logic [4:0] sel0, sel1, sel2, sel3, sel4, ack, lock_err;
   typedef struct {
      string      nm;
      logic [24:0] sel;
      logic [4:0]  ack;
      logic [4:0]  err;
   } exp_t;
   exp_t q [$];
   exp_t e;
   int compared = 0;
   int mismatched = 0;
   localparam logic [4:0] Z = 5'b00000;
   always #5 clk = ~clk;
   switch_allocator #(.LOCK_TIMEOUT(4), .TO_W(7)) dut (
      .clk(clk), .rst(rst), .req(req),
      .dest0(d[0]), .dest1(d[1]), .dest2(d[2]), .dest3(d[3]), .dest4(d[4]),
      .tail(tail), .out_rdy(out_rdy),
      .sel0(sel0), .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
      .ack(ack), .lock_err(lock_err)
   );
   function automatic logic [24:0] s(input int o, input int k);
      return 25'(1) << (o * 5 + k);
   endfunction
   task automatic step(input string nm, input logic rs, input logic [4:0] r, input logic [24:0] dv,
                       input logic [4:0] t, input logic [4:0] rdy,
                       input logic [24:0] es, input logic [4:0] ea, input logic [4:0] ee);
      exp_t x;
      @(posedge clk);
      #1;
      rst = rs;
      req = r;
      for (int k = 0; k < 5; k++) d[k] = dv[k*5 +: 5];
      tail = t;
      out_rdy = rdy;
      x.nm = nm; x.sel = es; x.ack = ea; x.err = ee;
      q.push_back(x);
   endtask
   always @(negedge clk)
      if (q.size() != 0) begin
         e = q.pop_front();
         compared++;
         if ({sel4, sel3, sel2, sel1, sel0, ack, lock_err} !== {e.sel, e.ack, e.err}) begin
            mismatched++;
            $display("FAIL %s: got sel=%h ack=%b lock_err=%b, expected sel=%h ack=%b lock_err=%b",
                     e.nm, {sel4, sel3, sel2, sel1, sel0}, ack, lock_err, e.sel, e.ack, e.err);
         end
      end
   initial begin
      for (int k = 0; k < 5; k++) d[k] = '0;
      repeat (2) step("reset_rand", 1, 5'($urandom), 25'($urandom), 5'($urandom), '1, '0, '0, '0);
      repeat (2) step("release_idle", 0, '0, '0, '0, '1, '0, '0, '0);
      step("single_flit", 0, 5'b00100, {Z, Z, 5'b01000, Z, Z}, 5'b00100, '1, s(3, 2), 5'b00100, '0);
      step("out3_free", 0, 5'b00001, {Z, Z, Z, Z, 5'b01000}, 5'b00001, '1, s(3, 0), 5'b00001, '0);
      step("rr_a", 0, 5'b10011, {5'b00001, Z, Z, 5'b00001, 5'b00001}, '1, '1, s(0, 0), 5'b00001, '0);
      step("rr_b", 0, 5'b10011, {5'b00001, Z, Z, 5'b00001, 5'b00001}, '1, '1, s(0, 1), 5'b00010, '0);
      step("rr_c", 0, 5'b10011, {5'b00001, Z, Z, 5'b00001, 5'b00001}, '1, '1, s(0, 4), 5'b10000, '0);
      step("rr_d", 0, 5'b10011, {5'b00001, Z, Z, 5'b00001, 5'b00001}, '1, '1, s(0, 0), 5'b00001, '0);
      step("bad_dest", 0, 5'b00011, {Z, Z, Z, Z, 5'b00011}, 5'b00011, '1, '0, '0, '0);
      step("parallel", 0, 5'b00101, {Z, Z, 5'b10000, Z, 5'b00010}, 5'b00101, '1, s(1, 0) | s(4, 2), 5'b00101, '0);
      step("pkt_head", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 1), 5'b00010, '0);
      step("pkt_body", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 1), 5'b00010, '0);
      step("pkt_tail", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01010, '1, s(2, 1), 5'b00010, '0);
      step("pkt_next", 0, 5'b01000, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 3), 5'b01000, '0);
      step("bp_head", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 1), 5'b00010, '0);
      step("bp_stall1", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, 5'b11011, '0, '0, '0);
      step("bp_stall2", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, 5'b11011, '0, '0, '0);
      step("bp_body", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 1), 5'b00010, '0);
      step("bp_tail", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01010, '1, s(2, 1), 5'b00010, '0);
      step("bp_next", 0, 5'b01000, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 3), 5'b01000, '0);
      step("mid_head", 0, 5'b00001, {Z, Z, Z, Z, 5'b01000}, 5'b00000, '1, s(3, 0), 5'b00001, '0);
      step("mid_rst", 1, 5'b00001, {Z, Z, Z, Z, 5'b01000}, 5'b00000, '1, '0, '0, '0);
      step("after_rst", 0, 5'b00100, {Z, Z, 5'b01000, Z, Z}, 5'b00100, '1, s(3, 2), 5'b00100, '0);
      step("to_head", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 1), 5'b00010, '0);
`ifdef SA_LOCK_TIMEOUT_EN
      repeat (4) step("to_idle", 0, 5'b01000, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, '0, '0, '0);
      step("to_break", 0, 5'b01000, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 3), 5'b01000, 5'b00100);
      step("to_after", 0, '0, '0, '0, '1, '0, '0, '0);
`else
      repeat (6) step("lock_hold", 0, 5'b01000, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, '0, '0, '0);
      step("lock_resume", 0, 5'b01010, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01010, '1, s(2, 1), 5'b00010, '0);
      step("lock_next", 0, 5'b01000, {Z, 5'b00100, Z, 5'b00100, Z}, 5'b01000, '1, s(2, 3), 5'b01000, '0);
`endif
      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, expected completion");
      $fatal(1);
   end
endmodule
